saradc_seq_ctrl: RTL

//  Conversion sequencer for the saradc macro. Drives its en/cal pins, waits for valid, and captures result.

---
 rtl/saradc_seq_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/saradc_seq_ctrl.sv
// saradc_seq_ctrl: conversion sequencer for the saradc macro with 2^N averaging,
// calibration with deferred requests, timeout abort and continuous burst repeat.
module saradc_seq_ctrl #(
  parameter int RES_W      = 10,
  parameter int AVG_MAX    = 3,
  parameter int TIMEOUT    = 255,
  parameter int CAL_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             continuous_i,
  input  logic             cal_req_i,
  input  logic [1:0]       avg_log2_i,
  input  logic [15:0]      period_i,
  input  logic             err_clr_i,
  output logic             adc_en_o,
  output logic             adc_cal_o,
  input  logic [RES_W-1:0] adc_result_i,
  input  logic             adc_valid_i,
  output logic [RES_W-1:0] data_o,
  output logic             data_valid_o,
  output logic             busy_o,
  output logic             timeout_err_o
);
  localparam int ACC_W = RES_W + AVG_MAX;
  localparam int CW = AVG_MAX + 1;
  localparam logic [1:0] AVG_CAP = 2'(AVG_MAX);
  typedef enum logic [2:0] {IDLE, CAL, ARM, WAIT, REARM, DONE, GAP} state_e;
  state_e state_q, state_d;
  logic [15:0] tmr_q, tmr_d, per_q, per_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] smp_q, smp_d, last;
  logic [1:0] avg_q, avg_d;
  logic [RES_W-1:0] data_q, data_d;
  logic pend_q, pend_d, err_q, err_d;
  assign sum = acc_q + ACC_W'(adc_result_i);
  assign last = (CW'(1) << avg_q) - CW'(1);
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    smp_d = smp_q;
    avg_d = avg_q;
    per_d = per_q;
    data_d = data_q;
    err_d = err_clr_i ? 1'b0 : err_q;
    case (state_q)
      IDLE: state_d = (pend_q || cal_req_i) ? CAL : (start_i || continuous_i) ? ARM : IDLE;
      CAL: state_d = (tmr_q == 16'(CAL_CYCLES - 1)) ? IDLE : CAL;
      ARM: begin
        avg_d = (avg_log2_i > AVG_CAP) ? AVG_CAP : avg_log2_i;
        per_d = period_i;
        acc_d = '0;
        smp_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (adc_valid_i) begin
          acc_d = sum;
          smp_d = smp_q + CW'(1);
          data_d = (smp_q == last) ? RES_W'(sum >> avg_q) : data_q;
          state_d = (smp_q == last) ? DONE : REARM;
        end else if (tmr_q == 16'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          state_d = IDLE;
        end
      end
      REARM: state_d = WAIT;
      DONE: state_d = pend_q ? CAL : !continuous_i ? IDLE : (per_q == 16'd0) ? ARM : GAP;
      GAP: state_d = !continuous_i ? IDLE : (tmr_q == per_q - 16'd1) ? ARM : GAP;
      default: state_d = IDLE;
    endcase
    // a request landing on the cycle a cal starts is kept for one more run
    pend_d = ((state_d == CAL && state_q != CAL) ? 1'b0 : pend_q) | (cal_req_i && state_q != IDLE);
    tmr_d = (state_d != state_q) ? 16'd0 : tmr_q + 16'd1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tmr_q <= '0;
      per_q <= '0;
      acc_q <= '0;
      smp_q <= '0;
      avg_q <= '0;
      data_q <= '0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      per_q <= per_d;
      acc_q <= acc_d;
      smp_q <= smp_d;
      avg_q <= avg_d;
      data_q <= data_d;
      pend_q <= pend_d;
      err_q <= err_d;
    end
  end
  assign adc_en_o = (state_q == ARM) || (state_q == WAIT);
  assign adc_cal_o = (state_q == CAL);
  assign data_valid_o = (state_q == DONE);
  assign busy_o = (state_q != IDLE);
  assign data_o = data_q;
  assign timeout_err_o = err_q;
endmodule
